// File: rtl/pulse_sweep_sequencer.sv
// Purpose : steps a pulse generator through a swept inter-pulse delay. Each
//           sweep point runs an exact number of shots, then the generator is
//           held idle while the delay changes and the RF chain settles.
// Latency : start sampled in cycle t -> SETTLE in t+1; generator released in
//           t+settle+2. All outputs are registered.
// Backpressure: none; start/abort are single-cycle strobes, and a start seen
//           while busy is dropped.
//
// Ports:
//   clk_pll     - 200 MHz PLL clock
//   reset       - asynchronous, active-high
//   start       - strobe, begin a sweep (ignored while busy or with a zero count)
//   abort       - strobe, stop the sweep; wins over start and end-of-point
//   period      - generator period, one shot = period+1 cycles
//   delay_start - delay applied to point 0
//   delay_step  - per-point delay increment magnitude
//   step_down   - 1 = subtract step per point, 0 = add
//   n_points    - number of sweep points
//   n_shots     - shots per point
//   settle      - hold cycles before each point (SETTLE lasts settle+1)
//   gen_hold    - drives generator reset; 1 = generator frozen at counter 0
//   delay_out   - drives generator delay
//   point_idx   - current sweep point, 0-based
//   shot_idx    - current shot within the point, 0-based
//   point_done  - one-cycle strobe when a point completes
//   busy        - sweep in progress
//   done        - sweep completed; level, cleared by the next start or abort

module pulse_sweep_sequencer #(
  parameter int CW = 32,
  parameter int NW = 16
) (
  input  logic          clk_pll,
  input  logic          reset,
  input  logic          start,
  input  logic          abort,
  input  logic [CW-1:0] period,
  input  logic [CW-1:0] delay_start,
  input  logic [CW-1:0] delay_step,
  input  logic          step_down,
  input  logic [NW-1:0] n_points,
  input  logic [NW-1:0] n_shots,
  input  logic [NW-1:0] settle,
  output logic          gen_hold,
  output logic [CW-1:0] delay_out,
  output logic [NW-1:0] point_idx,
  output logic [NW-1:0] shot_idx,
  output logic          point_done,
  output logic          busy,
  output logic          done
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETTLE = 2'd1,
    RUN    = 2'd2,
    DONE   = 2'd3
  } state_t;

  localparam logic [CW-1:0] C_ONE = CW'(1);
  localparam logic [NW-1:0] N_ONE = NW'(1);

  state_t        state;
  logic [CW-1:0] tcount;      // mirrors the generator's internal counter in RUN
  logic [NW-1:0] scount;      // settle counter, 0..settle_q

  // Configuration captured at start; host writes during a sweep are ignored.
  logic [CW-1:0] period_q;
  logic [CW-1:0] step_q;
  logic          down_q;
  logic [NW-1:0] npoints_q;
  logic [NW-1:0] nshots_q;
  logic [NW-1:0] settle_q;

  logic          cfg_ok;
  logic          shot_end;
  logic          last_shot;
  logic          last_point;
  logic [CW-1:0] delay_next;

  assign cfg_ok     = (n_points != '0) && (n_shots != '0);
  assign shot_end   = (tcount == period_q);
  assign last_shot  = (shot_idx == nshots_q - N_ONE);
  assign last_point = (point_idx == npoints_q - N_ONE);
  // Modulo 2^CW on purpose: the host owns the delay range.
  assign delay_next = down_q ? (delay_out - step_q) : (delay_out + step_q);

  always_ff @(posedge clk_pll or posedge reset) begin
    if (reset) begin
      state      <= IDLE;
      tcount     <= '0;
      scount     <= '0;
      period_q   <= '0;
      step_q     <= '0;
      down_q     <= 1'b0;
      npoints_q  <= '0;
      nshots_q   <= '0;
      settle_q   <= '0;
      gen_hold   <= 1'b1;
      delay_out  <= '0;
      point_idx  <= '0;
      shot_idx   <= '0;
      point_done <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
    end else begin
      point_done <= 1'b0;
      if (abort) begin
        // Indices and delay are left as they were for host inspection.
        state    <= IDLE;
        gen_hold <= 1'b1;
        busy     <= 1'b0;
        done     <= 1'b0;
      end else begin
        case (state)
          IDLE, DONE: begin
            if (start && cfg_ok) begin
              period_q  <= period;
              step_q    <= delay_step;
              down_q    <= step_down;
              npoints_q <= n_points;
              nshots_q  <= n_shots;
              settle_q  <= settle;
              delay_out <= delay_start;
              point_idx <= '0;
              scount    <= '0;
              done      <= 1'b0;
              busy      <= 1'b1;
              gen_hold  <= 1'b1;
              state     <= SETTLE;
            end
          end

          SETTLE: begin
            if (scount == settle_q) begin
              tcount   <= '0;
              shot_idx <= '0;
              gen_hold <= 1'b0;
              state    <= RUN;
            end else begin
              scount <= scount + N_ONE;
            end
          end

          RUN: begin
            if (shot_end) begin
              tcount <= '0;
              if (!last_shot) begin
                shot_idx <= shot_idx + N_ONE;
              end else begin
                // Hold rises on the same edge the generator wraps to 0, so the
                // delay update below is only ever seen by a frozen generator.
                point_done <= 1'b1;
                gen_hold   <= 1'b1;
                if (last_point) begin
                  busy  <= 1'b0;
                  done  <= 1'b1;
                  state <= DONE;
                end else begin
                  point_idx <= point_idx + N_ONE;
                  delay_out <= delay_next;
                  scount    <= '0;
                  state     <= SETTLE;
                end
              end
            end else begin
              tcount <= tcount + C_ONE;
            end
          end

          default: begin
            state    <= IDLE;
            gen_hold <= 1'b1;
            busy     <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule
